cmd_rx_arbiter: RTL and testbench
=================================

# cmd_rx_arbiter

Frame-level arbiter that shares the single command-identification parser between the two command UART receive FIFOs (CPU A link and CPU B link). It grants one FIFO at a time once a full command frame is buffered, and holds the grant until that frame has been consumed. It multiplexes the FIFO data and count toward the parser and routes the parser's pop strobe back to the granted FIFO only. It replaces ad-hoc count-compare source selection, so a source switch can never occur mid-frame.

## Interface
- FRAME_LEN, 8: bytes per command frame; eligibility threshold and lock length.
- CNT_W, 5: FIFO counter width (matches UART FIFO counter width).
- TO_CYC, 16'd50000: idle-cycle limit inside a locked frame (used only with timeout feature).
- clk  in  1  system clock.
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low.
- rf_count_a  in  CNT_W  UART A receive FIFO fill level.
- rdr_a  in  8  UART A receive FIFO head byte.
- rf_pop_a  out  1  pop strobe to UART A FIFO.
- rf_count_b  in  CNT_W  UART B receive FIFO fill level.
- rdr_b  in  8  UART B receive FIFO head byte.
- rf_pop_b  out  1  pop strobe to UART B FIFO.
- rf_count_m  out  CNT_W  fill level presented to parser.
- rdr_m  out  8  head byte presented to parser.
- rf_pop_m  in  1  pop strobe from parser.
- sel  out  1  granted source, 0 = A, 1 = B.
- lock  out  1  high while a frame grant is held.
- frame_done  out  1  one-cycle pulse when FRAME_LEN pops completed.
- timeout_err  out  1  one-cycle pulse on frame abandonment (0 when feature compiled out).

## Operation
- States: IDLE, LOCK, RELEASE. Reset: IDLE, sel=0, lock=0, frame_done=0, timeout_err=0, byte counter=0, idle counter=0, last_grant=1 (so A wins first tie).
- Eligibility: elig_x = (rf_count_x >= FRAME_LEN), unsigned compare at CNT_W bits.
- IDLE: only A eligible -> grant A; only B -> grant B; both -> grant ~last_grant (round-robin); none -> stay. On grant: sel<=source, last_grant<=source, lock<=1, state<=LOCK, byte counter<=0.
- LOCK: rf_pop_<sel> = rf_pop_m, other pop forced 0; rf_count_m = granted count. Each rf_pop_m increments byte counter; the pop bringing it to FRAME_LEN moves to RELEASE, pulses frame_done, clears lock.
- RELEASE: one cycle, no grants, then IDLE. Lets the FIFO count settle after the final pop.
- Outside LOCK: rf_pop_a=rf_pop_b=0 (parser pops dropped), rf_count_m=0, sel holds last value.
- rdr_m = sel ? rdr_b : rdr_a in all states.
- The non-granted FIFO may fill freely during LOCK; it is evaluated at the next IDLE.
- Reset asserted mid-frame: immediate return to reset values; partially consumed frame is not resumed.

## Timing
- rf_pop_x, rdr_m: combinational from rf_pop_m / sel, zero latency.
- Grant: elig sampled in IDLE at edge N -> lock=1, sel valid, rf_count_m nonzero after edge N.
- Release: last pop sampled at edge M -> frame_done high and lock low for cycle after M; RELEASE that cycle; IDLE after edge M+1; earliest next lock after edge M+2.
- Minimum gap between frames: 2 cycles with lock low.
- sel, lock, frame_done, timeout_err are registered outputs; rf_count_m, rf_pop_x, rdr_m are combinational.

## Configuration
- ARB_TIMEOUT_EN defined: in LOCK, 16-bit idle counter clears on any rf_pop_m, else increments; at TO_CYC-1 with no pop, go to RELEASE, pulse timeout_err, clear lock and byte counter. Final pop and timeout on same edge: frame_done wins, no timeout_err.
- ARB_TIMEOUT_EN undefined: no idle counter; LOCK held until FRAME_LEN pops; timeout_err tied 0.

## Test plan
- A count 8, B 0; parser pops 8 -> lock 1 cycle after, sel=0, rf_pop_a mirrors 8 pops, rf_pop_b=0, frame_done after 8th pop.
- A and B both 8 at same edge -> A granted first; after A frame, B granted 2 cycles after lock drops; next tie grants A.
- B reaches 8 while A locked after 3 pops -> sel stays 0 until A's 8th pop; then B granted.
- rf_pop_m pulsed in IDLE with A count 7 -> rf_pop_a=rf_pop_b=0, rf_count_m=0, no lock.
- ARB_TIMEOUT_EN, TO_CYC=20, A locked, 2 pops then none -> timeout_err pulse 20 cycles after last pop, lock=0, next grant re-evaluated.
- rst_n low after 4 pops of B frame -> lock=0, sel=0, pops blocked; after release, A wins first tie.

Source files
------------

// File: rtl/cmd_rx_arbiter_if.sv
// cmd_rx_arbiter_if: bundles the two UART receive FIFO ports, the parser port and arbiter status.
// Latency: none, wiring only.
// Backpressure: none at this level. Pops reach a FIFO only through the arbiter's grant.
interface cmd_rx_arbiter_if #(
    parameter int CNT_W = 5
);
    logic [CNT_W-1:0] rf_count_a;
    logic [7:0]       rdr_a;
    logic             rf_pop_a;
    logic [CNT_W-1:0] rf_count_b;
    logic [7:0]       rdr_b;
    logic             rf_pop_b;
    logic [CNT_W-1:0] rf_count_m;
    logic [7:0]       rdr_m;
    logic             rf_pop_m;
    logic             sel;
    logic             lock;
    logic             frame_done;
    logic             timeout_err;

    // Arbiter side: consumes FIFO levels/heads and parser pops, drives everything else.
    modport master (
        input  rf_count_a, rdr_a, rf_count_b, rdr_b, rf_pop_m,
        output rf_pop_a, rf_pop_b, rf_count_m, rdr_m,
        output sel, lock, frame_done, timeout_err
    );

    // Environment side: the FIFOs plus the parser.
    modport slave (
        output rf_count_a, rdr_a, rf_count_b, rdr_b, rf_pop_m,
        input  rf_pop_a, rf_pop_b, rf_count_m, rdr_m,
        input  sel, lock, frame_done, timeout_err
    );
endinterface

// File: rtl/cmd_rx_arbiter.sv
// cmd_rx_arbiter: grants one UART receive FIFO at a time to the shared command parser, one frame per grant.
// Latency: the grant registers one cycle after a full frame is buffered. Pop, data and count muxing are combinational.
// Backpressure: parser pops outside a held frame are dropped. The grant holds until FRAME_LEN pops (ARB_TIMEOUT_EN: or an idle timeout).
module cmd_rx_arbiter #(
    parameter int          FRAME_LEN = 8,
    parameter int          CNT_W     = 5,
    parameter logic [15:0] TO_CYC    = 16'd50000
) (
    input  logic                clk,
    input  logic                rst_n,
    cmd_rx_arbiter_if.master    bus
);
    localparam int               BC_W        = $clog2(FRAME_LEN + 1);
    localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
    localparam logic [BC_W-1:0]  LAST_BYTE_C = BC_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOCK    = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            sel_q, sel_d;
    logic            lock_q, lock_d;
    logic            last_grant_q, last_grant_d;
    logic            frame_done_q, frame_done_d;
    logic            timeout_err_q, timeout_err_d;
    logic [BC_W-1:0] byte_cnt_q, byte_cnt_d;
`ifdef ARB_TIMEOUT_EN
    logic [15:0]     idle_cnt_q, idle_cnt_d;
`endif

    logic elig_a;
    logic elig_b;
    logic grant_b;
    logic in_lock;

    // A source is eligible only when a whole frame is already buffered.
    // On a tie the source that did not win last time is granted.
    assign elig_a  = (bus.rf_count_a >= FRAME_LEN_C);
    assign elig_b  = (bus.rf_count_b >= FRAME_LEN_C);
    assign grant_b = elig_b & (~elig_a | ~last_grant_q);
    assign in_lock = (state_q == ST_LOCK);

    // Parser-facing mux: pops and count pass through only while a frame is held. Data follows sel at all times.
    assign bus.rf_pop_a   = in_lock & ~sel_q & bus.rf_pop_m;
    assign bus.rf_pop_b   = in_lock &  sel_q & bus.rf_pop_m;
    assign bus.rf_count_m = in_lock ? (sel_q ? bus.rf_count_b : bus.rf_count_a) : '0;
    assign bus.rdr_m      = sel_q ? bus.rdr_b : bus.rdr_a;

    assign bus.sel         = sel_q;
    assign bus.lock        = lock_q;
    assign bus.frame_done  = frame_done_q;
    assign bus.timeout_err = timeout_err_q;

    // Next-state logic: grant in IDLE, count pops in LOCK, spend one settle cycle in RELEASE.
    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        lock_d        = lock_q;
        last_grant_d  = last_grant_q;
        byte_cnt_d    = byte_cnt_q;
        frame_done_d  = 1'b0;
        timeout_err_d = 1'b0;
`ifdef ARB_TIMEOUT_EN
        idle_cnt_d    = idle_cnt_q;
`else
        // The timeout is compiled out. TO_CYC still appears here so that both builds keep the same parameter list.
        timeout_err_d = (TO_CYC == 16'd0) & 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (elig_a || elig_b) begin
                    sel_d        = grant_b;
                    last_grant_d = grant_b;
                    lock_d       = 1'b1;
                    byte_cnt_d   = '0;
                    state_d      = ST_LOCK;
`ifdef ARB_TIMEOUT_EN
                    idle_cnt_d   = '0;
`endif
                end
            end
            ST_LOCK: begin
                if (bus.rf_pop_m) begin
`ifdef ARB_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                    if (byte_cnt_q == LAST_BYTE_C) begin
                        // The final pop of a frame takes priority over a coincident timeout, because the pop clears the idle count.
                        byte_cnt_d   = '0;
                        lock_d       = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = ST_RELEASE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                    end
                end
`ifdef ARB_TIMEOUT_EN
                else if (idle_cnt_q == TO_CYC - 16'd1) begin
                    // The parser stalled mid-frame. Abandon the frame so the other link is not starved.
                    byte_cnt_d    = '0;
                    idle_cnt_d    = '0;
                    lock_d        = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = ST_RELEASE;
                end else begin
                    idle_cnt_d = idle_cnt_q + 16'd1;
                end
`endif
            end
            ST_RELEASE: begin
                // One quiet cycle so the FIFO count reflects the final pop before eligibility is re-evaluated.
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                lock_d  = 1'b0;
            end
        endcase
    end

    // State and registered outputs. last_grant resets to B so that A wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            sel_q         <= 1'b0;
            lock_q        <= 1'b0;
            last_grant_q  <= 1'b1;
            frame_done_q  <= 1'b0;
            timeout_err_q <= 1'b0;
            byte_cnt_q    <= '0;
`ifdef ARB_TIMEOUT_EN
            idle_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            lock_q        <= lock_d;
            last_grant_q  <= last_grant_d;
            frame_done_q  <= frame_done_d;
            timeout_err_q <= timeout_err_d;
            byte_cnt_q    <= byte_cnt_d;
`ifdef ARB_TIMEOUT_EN
            idle_cnt_q    <= idle_cnt_d;
`endif
        end
    end
endmodule

// File: tb/tb_cmd_rx_arbiter.sv
// tb_cmd_rx_arbiter: scenario tasks plus a randomized run, checked against a frame-level reference model.
// Latency: the bench drives inputs 1ns after each rising edge and samples outputs 2ns after it.
// Backpressure: the FIFOs are modelled as byte queues, and only the DUT's routed pops remove bytes from them.
module tb_cmd_rx_arbiter;
    localparam int FL  = 8;
    localparam int CW  = 5;
    localparam int TOC = 20;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    cmd_rx_arbiter_if #(.CNT_W(CW)) bus();

    cmd_rx_arbiter #(
        .FRAME_LEN (FL),
        .CNT_W     (CW),
        .TO_CYC    (16'(TOC))
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic       pop_m = 1'b0;

    // Reference model at frame level: is a frame held, from which source, bytes taken, and the gap before the next grant.
    bit m_held, m_sel, m_last, m_done, m_to;
    int m_taken, m_gap;
`ifdef ARB_TIMEOUT_EN
    int m_quiet;
`endif

    task automatic model_reset();
        m_held = 0; m_sel = 0; m_last = 1; m_done = 0; m_to = 0; m_taken = 0; m_gap = 0;
`ifdef ARB_TIMEOUT_EN
        m_quiet = 0;
`endif
    endtask

    task automatic drive();
        bus.rf_count_a = CW'(qa.size());
        bus.rf_count_b = CW'(qb.size());
        bus.rdr_a      = (qa.size() > 0) ? qa[0] : 8'h00;
        bus.rdr_b      = (qb.size() > 0) ? qb[0] : 8'h00;
        bus.rf_pop_m   = pop_m;
    endtask

    task automatic push_a(int n);
        for (int i = 0; i < n; i++) if (qa.size() < 31) qa.push_back(8'($urandom));
        drive();
    endtask

    task automatic push_b(int n);
        for (int i = 0; i < n; i++) if (qb.size() < 31) qb.push_back(8'($urandom));
        drive();
    endtask

    task automatic set_pop(logic p);
        pop_m = p;
        drive();
        #1;
    endtask

    // Advance one clock. The model and the FIFO queues move with the DUT.
    task automatic tick();
        bit pa, pb;
        int ca, cb;
        pa = bus.rf_pop_a; pb = bus.rf_pop_b;
        ca = qa.size();    cb = qb.size();
        m_done = 0; m_to = 0;
        if (m_held) begin
            if (pop_m) begin
                m_taken++;
`ifdef ARB_TIMEOUT_EN
                m_quiet = 0;
`endif
                if (m_taken == FL) begin m_held = 0; m_done = 1; m_gap = 1; end
            end
`ifdef ARB_TIMEOUT_EN
            else if (m_quiet == TOC - 1) begin
                m_held = 0; m_to = 1; m_gap = 1; m_taken = 0; m_quiet = 0;
            end else m_quiet++;
`endif
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (ca >= FL || cb >= FL) begin
            m_sel   = (cb >= FL) && (ca < FL || m_last == 0);
            m_last  = m_sel;
            m_held  = 1;
            m_taken = 0;
`ifdef ARB_TIMEOUT_EN
            m_quiet = 0;
`endif
        end
        @(posedge clk); #1;
        if (pa && qa.size() > 0) void'(qa.pop_front());
        if (pb && qb.size() > 0) void'(qb.pop_front());
        drive();
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        qa.delete(); qb.delete();
        pop_m = 1'b0;
        drive();
        repeat (2) begin @(posedge clk); #1; end
        rst_n = 1'b1;
        model_reset();
    endtask

    // Pop until neither FIFO holds a frame and the arbiter is idle, then discard the partial leftovers.
    task automatic drain();
        bit ok = 0;
        for (int k = 0; k < 400 && !ok; k++) begin
            set_pop(1'b1);
            tick();
            if (qa.size() < FL && qb.size() < FL && !m_held && m_gap == 0) ok = 1;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL drain_bound: got not-idle want idle within 400 cycles"); end
        qa.delete(); qb.delete();
        set_pop(1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        push_a(8);
        set_pop(1'b1);
        repeat (2) begin @(posedge clk); #1; end
        checks++; if (bus.lock !== 1'b0)        begin errors++; $display("FAIL rst_lock: got %b want 0", bus.lock); end
        checks++; if (bus.sel !== 1'b0)         begin errors++; $display("FAIL rst_sel: got %b want 0", bus.sel); end
        checks++; if (bus.frame_done !== 1'b0)  begin errors++; $display("FAIL rst_done: got %b want 0", bus.frame_done); end
        checks++; if (bus.timeout_err !== 1'b0) begin errors++; $display("FAIL rst_to: got %b want 0", bus.timeout_err); end
        checks++; if (bus.rf_count_m !== '0)    begin errors++; $display("FAIL rst_count_m: got %0d want 0", bus.rf_count_m); end
        checks++; if ({bus.rf_pop_a, bus.rf_pop_b} !== 2'b00) begin errors++; $display("FAIL rst_pops: got %b want 00", {bus.rf_pop_a, bus.rf_pop_b}); end
        apply_reset();
    endtask

    task automatic test_single_a();
        push_a(8);
        set_pop(1'b0);
        checks++; if (bus.lock !== 1'b0) begin errors++; $display("FAIL single_prelock: got %b want 0", bus.lock); end
        tick();
        checks++; if ({bus.lock, bus.sel} !== 2'b10) begin errors++; $display("FAIL single_grant: got lock,sel=%b want 10", {bus.lock, bus.sel}); end
        for (int i = 0; i < FL; i++) begin
            set_pop(1'b1);
            checks++; if ({bus.rf_pop_a, bus.rf_pop_b} !== 2'b10) begin errors++; $display("FAIL single_pop%0d: got %b want 10", i, {bus.rf_pop_a, bus.rf_pop_b}); end
            checks++; if (bus.rf_count_m !== CW'(FL - i)) begin errors++; $display("FAIL single_cnt%0d: got %0d want %0d", i, bus.rf_count_m, FL - i); end
            checks++; if (bus.rdr_m !== qa[0]) begin errors++; $display("FAIL single_rdr%0d: got %h want %h", i, bus.rdr_m, qa[0]); end
            tick();
            if (i < FL - 1) begin
                checks++; if ({bus.lock, bus.frame_done} !== 2'b10) begin errors++; $display("FAIL single_hold%0d: got lock,done=%b want 10", i, {bus.lock, bus.frame_done}); end
            end
        end
        checks++; if ({bus.lock, bus.frame_done} !== 2'b01) begin errors++; $display("FAIL single_end: got lock,done=%b want 01", {bus.lock, bus.frame_done}); end
        set_pop(1'b0);
        tick();
        checks++; if (bus.frame_done !== 1'b0) begin errors++; $display("FAIL single_done_pulse: got %b want 0", bus.frame_done); end
    endtask

    task automatic test_tie();
        apply_reset();
        push_a(8); push_b(8);
        set_pop(1'b0);
        tick();
        checks++; if ({bus.lock, bus.sel} !== 2'b10) begin errors++; $display("FAIL tie_first: got lock,sel=%b want 10", {bus.lock, bus.sel}); end
        repeat (FL) begin
            set_pop(1'b1);
            checks++; if ({bus.rf_pop_a, bus.rf_pop_b} !== 2'b10) begin errors++; $display("FAIL tie_pop_a: got %b want 10", {bus.rf_pop_a, bus.rf_pop_b}); end
            tick();
        end
        set_pop(1'b0);
        checks++; if (bus.lock !== 1'b0) begin errors++; $display("FAIL tie_gap1: got %b want 0", bus.lock); end
        tick();
        checks++; if (bus.lock !== 1'b0) begin errors++; $display("FAIL tie_gap2: got %b want 0", bus.lock); end
        tick();
        checks++; if ({bus.lock, bus.sel} !== 2'b11) begin errors++; $display("FAIL tie_second: got lock,sel=%b want 11", {bus.lock, bus.sel}); end
        repeat (FL) begin
            set_pop(1'b1);
            checks++; if ({bus.rf_pop_a, bus.rf_pop_b} !== 2'b01) begin errors++; $display("FAIL tie_pop_b: got %b want 01", {bus.rf_pop_a, bus.rf_pop_b}); end
            tick();
        end
        push_a(8); push_b(8);
        set_pop(1'b0);
        tick(); tick();
        checks++; if ({bus.lock, bus.sel} !== 2'b10) begin errors++; $display("FAIL tie_third: got lock,sel=%b want 10", {bus.lock, bus.sel}); end
        drain();
    endtask

    task automatic test_b_during_a();
        push_a(8);
        set_pop(1'b0);
        tick();
        repeat (3) begin set_pop(1'b1); tick(); end
        push_b(8);
        repeat (FL - 3) begin
            set_pop(1'b1);
            checks++; if ({bus.sel, bus.rf_pop_b} !== 2'b00) begin errors++; $display("FAIL mid_hold: got sel,pop_b=%b want 00", {bus.sel, bus.rf_pop_b}); end
            tick();
        end
        set_pop(1'b0);
        tick();
        checks++; if (bus.lock !== 1'b0) begin errors++; $display("FAIL mid_gap: got %b want 0", bus.lock); end
        tick();
        checks++; if ({bus.lock, bus.sel} !== 2'b11) begin errors++; $display("FAIL mid_grant_b: got lock,sel=%b want 11", {bus.lock, bus.sel}); end
        drain();
    endtask

    task automatic test_idle_pop();
        push_a(7);
        repeat (5) begin
            set_pop(1'b1);
            checks++; if ({bus.rf_pop_a, bus.rf_pop_b, bus.lock} !== 3'b000) begin errors++; $display("FAIL idle_pop: got pa,pb,lock=%b want 000", {bus.rf_pop_a, bus.rf_pop_b, bus.lock}); end
            checks++; if (bus.rf_count_m !== '0) begin errors++; $display("FAIL idle_cnt: got %0d want 0", bus.rf_count_m); end
            tick();
        end
        checks++; if (qa.size() != 7) begin errors++; $display("FAIL idle_fifo: got %0d want 7", qa.size()); end
        qa.delete();
        set_pop(1'b0);
    endtask

    task automatic test_reset_mid();
        push_b(8);
        set_pop(1'b0);
        tick();
        checks++; if ({bus.lock, bus.sel} !== 2'b11) begin errors++; $display("FAIL rmid_grant: got lock,sel=%b want 11", {bus.lock, bus.sel}); end
        repeat (4) begin set_pop(1'b1); tick(); end
        rst_n = 1'b0;
        set_pop(1'b1);
        checks++; if ({bus.lock, bus.sel} !== 2'b00) begin errors++; $display("FAIL rmid_state: got lock,sel=%b want 00", {bus.lock, bus.sel}); end
        checks++; if ({bus.rf_pop_a, bus.rf_pop_b} !== 2'b00) begin errors++; $display("FAIL rmid_pops: got %b want 00", {bus.rf_pop_a, bus.rf_pop_b}); end
        @(posedge clk); #1;
        qa.delete(); qb.delete();
        push_a(8); push_b(8);
        rst_n = 1'b1;
        model_reset();
        set_pop(1'b0);
        tick();
        checks++; if ({bus.lock, bus.sel} !== 2'b10) begin errors++; $display("FAIL rmid_tie: got lock,sel=%b want 10", {bus.lock, bus.sel}); end
        drain();
    endtask

    task automatic test_timeout();
        push_a(8);
        set_pop(1'b0);
        tick();
        repeat (2) begin set_pop(1'b1); tick(); end
`ifdef ARB_TIMEOUT_EN
        for (int k = 1; k <= TOC; k++) begin
            set_pop(1'b0);
            tick();
            if (k < TOC) begin
                if (bus.timeout_err !== 1'b0 || bus.lock !== 1'b1) begin
                    checks++; errors++;
                    $display("FAIL to_early%0d: got to,lock=%b want 01", k, {bus.timeout_err, bus.lock});
                end
            end else begin
                checks++; if ({bus.timeout_err, bus.lock} !== 2'b10) begin errors++; $display("FAIL to_fire: got to,lock=%b want 10", {bus.timeout_err, bus.lock}); end
            end
        end
        tick();
        checks++; if ({bus.timeout_err, bus.lock} !== 2'b00) begin errors++; $display("FAIL to_pulse: got to,lock=%b want 00", {bus.timeout_err, bus.lock}); end
        push_a(2);
        set_pop(1'b0);
        tick();
        checks++; if ({bus.lock, bus.sel} !== 2'b10) begin errors++; $display("FAIL to_regrant: got lock,sel=%b want 10", {bus.lock, bus.sel}); end
`else
        repeat (40) begin
            set_pop(1'b0);
            tick();
            checks++; if ({bus.timeout_err, bus.lock} !== 2'b01) begin errors++; $display("FAIL nto_hold: got to,lock=%b want 01", {bus.timeout_err, bus.lock}); end
        end
`endif
        drain();
    endtask

    task automatic test_random();
        for (int c = 0; c < 3000; c++) begin
            bit exp_pa, exp_pb;
            logic [CW-1:0] exp_cnt;
            logic [7:0]    exp_rdr;
            if ($urandom_range(0, 3) == 0) push_a(1);
            if ($urandom_range(0, 3) == 0) push_b(1);
            set_pop(1'($urandom_range(0, 1)));
            exp_pa  = m_held && !m_sel && pop_m;
            exp_pb  = m_held &&  m_sel && pop_m;
            exp_cnt = m_held ? CW'(m_sel ? qb.size() : qa.size()) : '0;
            exp_rdr = m_sel ? bus.rdr_b : bus.rdr_a;
            checks++; if (bus.lock !== m_held)       begin errors++; $display("FAIL rnd_lock@%0d: got %b want %b", c, bus.lock, m_held); end
            checks++; if (bus.sel !== m_sel)         begin errors++; $display("FAIL rnd_sel@%0d: got %b want %b", c, bus.sel, m_sel); end
            checks++; if (bus.frame_done !== m_done) begin errors++; $display("FAIL rnd_done@%0d: got %b want %b", c, bus.frame_done, m_done); end
            checks++; if (bus.timeout_err !== m_to)  begin errors++; $display("FAIL rnd_to@%0d: got %b want %b", c, bus.timeout_err, m_to); end
            checks++; if ({bus.rf_pop_a, bus.rf_pop_b} !== {exp_pa, exp_pb}) begin errors++; $display("FAIL rnd_pops@%0d: got %b want %b", c, {bus.rf_pop_a, bus.rf_pop_b}, {exp_pa, exp_pb}); end
            checks++; if (bus.rf_count_m !== exp_cnt) begin errors++; $display("FAIL rnd_cnt@%0d: got %0d want %0d", c, bus.rf_count_m, exp_cnt); end
            checks++; if (bus.rdr_m !== exp_rdr)      begin errors++; $display("FAIL rnd_rdr@%0d: got %h want %h", c, bus.rdr_m, exp_rdr); end
            tick();
        end
    endtask

    initial begin
        model_reset();
        drive();
        test_reset();
        test_single_a();
        test_tie();
        test_b_during_a();
        test_idle_pop();
        test_reset_mid();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion want finish before 2ms");
        $fatal(1, "watchdog expired");
    end
endmodule
